// File: rtl/tx_fifo.sv
// ---------------------------------------------------------------------------
// tx_fifo
// Transmit-side word buffer between the APB register block and the frame
// transmitter core. Each rising edge of write_enable_tx captures one word
// from reg_transmit_tx into an 8-deep queue. rd_en_tx pops the oldest word
// onto a registered output with a one-cycle valid pulse. flush_tx empties
// the queue and clears the sticky error flags.
//
// Ports
//   PCLK_tx             in   clock, rising edge
//   PRESETn_tx          in   asynchronous active-low reset
//   write_enable_tx     in   write request level (one push per rising edge)
//   reg_transmit_tx     in   write data, sampled in the push cycle
//   flush_tx            in   synchronous flush, highest priority
//   rd_en_tx            in   pop request
//   fifo_dout_tx        out  registered popped word
//   fifo_dout_valid_tx  out  one-cycle pulse with each popped word
//   fifo_count_tx       out  occupancy 0..DEPTH
//   fifo_full_tx        out  count == DEPTH
//   fifo_empty_tx       out  count == 0
//   status_tx           out  {full, empty, almost_full, overflow, underflow, 3'b0}
// ---------------------------------------------------------------------------
module tx_fifo #(
  parameter int DATAWIDTH         = 12,
  parameter int ADDRWIDTH         = 3,
  parameter int ALMOST_FULL_LEVEL = 6
) (
  input  logic                 PCLK_tx,
  input  logic                 PRESETn_tx,
  input  logic                 write_enable_tx,
  input  logic [DATAWIDTH-1:0] reg_transmit_tx,
  input  logic                 flush_tx,
  input  logic                 rd_en_tx,
  output logic [DATAWIDTH-1:0] fifo_dout_tx,
  output logic                 fifo_dout_valid_tx,
  output logic [ADDRWIDTH:0]   fifo_count_tx,
  output logic                 fifo_full_tx,
  output logic                 fifo_empty_tx,
  output logic [7:0]           status_tx
);

  localparam int                 DEPTH    = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] DEPTH_C  = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [ADDRWIDTH:0] AFULL_C  = (ADDRWIDTH+1)'(ALMOST_FULL_LEVEL);

  logic [DATAWIDTH-1:0] mem [DEPTH];

  logic [ADDRWIDTH-1:0] wr_ptr_reg;
  logic [ADDRWIDTH-1:0] rd_ptr_reg;
  logic [ADDRWIDTH:0]   count_reg;
  logic [ADDRWIDTH:0]   count_next;
  logic                 we_d_reg;
  logic                 overflow_reg;
  logic                 underflow_reg;
  logic [DATAWIDTH-1:0] dout_reg;
  logic                 dout_valid_reg;

  logic push_req;
  logic pop_req;
  logic do_push;
  logic do_pop;
  logic full;
  logic empty;
  logic almost_full;

  assign full        = (count_reg == DEPTH_C);
  assign empty       = (count_reg == '0);
  assign almost_full = (count_reg >= AFULL_C);

  // A held write level yields a single push: only the low-to-high transition counts.
  assign push_req = write_enable_tx & ~we_d_reg;
  assign pop_req  = rd_en_tx;

  // A pop from a full queue frees the slot the simultaneous push lands in.
  // A pop from an empty queue is rejected even if a push arrives with it.
  assign do_pop  = pop_req & ~empty;
  assign do_push = push_req & (~full | do_pop);

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset; a location is only read once it has been written,
  // because pops are gated by a non-zero count.
  always_ff @(posedge PCLK_tx) begin
    if (!flush_tx && do_push) begin
      mem[wr_ptr_reg] <= reg_transmit_tx;
    end
  end

  always_ff @(posedge PCLK_tx or negedge PRESETn_tx) begin
    if (!PRESETn_tx) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      we_d_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      // The edge detector keeps tracking during flush so a level held
      // across the flush does not produce a late push afterwards.
      we_d_reg <= write_enable_tx;
      if (flush_tx) begin
        wr_ptr_reg     <= '0;
        rd_ptr_reg     <= '0;
        count_reg      <= '0;
        overflow_reg   <= 1'b0;
        underflow_reg  <= 1'b0;
        dout_reg       <= '0;
        dout_valid_reg <= 1'b0;
      end else begin
        dout_valid_reg <= do_pop;
        if (do_pop) begin
          dout_reg   <= mem[rd_ptr_reg];
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        if (do_push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (push_req && !do_push) begin
          overflow_reg <= 1'b1;
        end
        if (pop_req && empty) begin
          underflow_reg <= 1'b1;
        end
        count_reg <= count_next;
      end
    end
  end

  assign fifo_dout_tx       = dout_reg;
  assign fifo_dout_valid_tx = dout_valid_reg;
  assign fifo_count_tx      = count_reg;
  assign fifo_full_tx       = full;
  assign fifo_empty_tx      = empty;
  assign status_tx          = {full, empty, almost_full, overflow_reg, underflow_reg, 3'b000};

endmodule

// File: tb/tb_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_tx_fifo
// Self-checking bench for tx_fifo. A queue-based reference model tracks the
// expected contents, sticky flags and popped word; every clock cycle all
// outputs are compared against it. Directed sequences cover the documented
// scenarios, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_tx_fifo;

  localparam int DW    = 12;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic          PCLK_tx;
  logic          PRESETn_tx;
  logic          write_enable_tx;
  logic [DW-1:0] reg_transmit_tx;
  logic          flush_tx;
  logic          rd_en_tx;
  logic [DW-1:0] fifo_dout_tx;
  logic          fifo_dout_valid_tx;
  logic [AW:0]   fifo_count_tx;
  logic          fifo_full_tx;
  logic          fifo_empty_tx;
  logic [7:0]    status_tx;

  tx_fifo #(
    .DATAWIDTH(DW),
    .ADDRWIDTH(AW),
    .ALMOST_FULL_LEVEL(AFULL)
  ) dut (
    .PCLK_tx(PCLK_tx),
    .PRESETn_tx(PRESETn_tx),
    .write_enable_tx(write_enable_tx),
    .reg_transmit_tx(reg_transmit_tx),
    .flush_tx(flush_tx),
    .rd_en_tx(rd_en_tx),
    .fifo_dout_tx(fifo_dout_tx),
    .fifo_dout_valid_tx(fifo_dout_valid_tx),
    .fifo_count_tx(fifo_count_tx),
    .fifo_full_tx(fifo_full_tx),
    .fifo_empty_tx(fifo_empty_tx),
    .status_tx(status_tx)
  );

  initial PCLK_tx = 1'b0;
  always #5 PCLK_tx = ~PCLK_tx;

  int n_vec;
  int n_bad;

  // Reference model state
  logic [DW-1:0] m_q[$];
  logic          m_prev_we;
  logic          m_ovf;
  logic          m_unf;
  logic [DW-1:0] m_dout;
  logic          m_valid;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev_we = 1'b0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    m_dout    = '0;
    m_valid   = 1'b0;
  endtask

  // Apply the documented rules to the inputs sampled at this edge.
  task automatic model_edge(input logic we, input logic [DW-1:0] d,
                            input logic fl, input logic rd);
    logic push;
    push      = we & ~m_prev_we;
    m_prev_we = we;
    if (fl) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_dout  = '0;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      // Pop considered first: a pop on a full queue frees the slot,
      // a pop on an empty queue is rejected before the push lands.
      if (rd) begin
        if (m_q.size() > 0) begin
          m_dout  = m_q.pop_front();
          m_valid = 1'b1;
        end else begin
          m_unf = 1'b1;
        end
      end
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else                    m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [7:0] model_status();
    int n;
    n = m_q.size();
    return {(n == DEPTH), (n == 0), (n >= AFULL), m_ovf, m_unf, 3'b000};
  endfunction

  task automatic compare_all(input string tag);
    int n;
    n = m_q.size();
    check_val({tag, ".dout"},   32'(fifo_dout_tx),       32'(m_dout));
    check_val({tag, ".valid"},  32'(fifo_dout_valid_tx), 32'(m_valid));
    check_val({tag, ".count"},  32'(fifo_count_tx),      32'(n));
    check_val({tag, ".full"},   32'(fifo_full_tx),       32'(n == DEPTH));
    check_val({tag, ".empty"},  32'(fifo_empty_tx),      32'(n == 0));
    check_val({tag, ".status"}, 32'(status_tx),          32'(model_status()));
  endtask

  // One clock: sample inputs at the edge, update the model, compare 1ns later.
  task automatic step(input string tag);
    logic          we;
    logic [DW-1:0] d;
    logic          fl;
    logic          rd;
    @(posedge PCLK_tx);
    we = write_enable_tx;
    d  = reg_transmit_tx;
    fl = flush_tx;
    rd = rd_en_tx;
    model_edge(we, d, fl, rd);
    #1;
    compare_all(tag);
  endtask

  task automatic push_word(input logic [DW-1:0] w, input int hold);
    write_enable_tx = 1'b1;
    reg_transmit_tx = w;
    repeat (hold) step("push");
    write_enable_tx = 1'b0;
    reg_transmit_tx = DW'($urandom);
    step("gap");
  endtask

  task automatic pop_n(input int n);
    rd_en_tx = 1'b1;
    repeat (n) step("pop");
    rd_en_tx = 1'b0;
  endtask

  task automatic do_flush();
    flush_tx = 1'b1;
    step("flush");
    flush_tx = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    model_reset();
    PRESETn_tx      = 1'b0;
    write_enable_tx = 1'b0;
    reg_transmit_tx = '0;
    flush_tx        = 1'b0;
    rd_en_tx        = 1'b0;
    repeat (3) @(posedge PCLK_tx);
    #1;
    PRESETn_tx = 1'b1;
    compare_all("reset");

    // Reset then idle
    repeat (2) step("idle");
    check_val("idle_status", 32'(status_tx), 32'h40);
    check_val("idle_dout",   32'(fifo_dout_tx), 32'h0);

    // Three pushes with 2-cycle levels, then three consecutive pops
    push_word(12'hA01, 2);
    push_word(12'hA02, 2);
    push_word(12'hA03, 2);
    check_val("three_push_count", 32'(fifo_count_tx), 32'd3);
    rd_en_tx = 1'b1;
    step("pop1"); check_val("pop1_dout", 32'(fifo_dout_tx), 32'hA01);
    step("pop2"); check_val("pop2_dout", 32'(fifo_dout_tx), 32'hA02);
    step("pop3"); check_val("pop3_dout", 32'(fifo_dout_tx), 32'hA03);
    rd_en_tx = 1'b0;
    step("drain");
    check_val("drain_count", 32'(fifo_count_tx), 32'd0);

    // Nine pushes: almost full, full, overflow; then eight pops across the wrap
    for (int i = 1; i <= 9; i++) begin
      push_word(12'hB00 + 12'(i), 1);
      if (i == 6) check_val("afull_bit", 32'(status_tx[5]), 32'd1);
      if (i == 8) check_val("full_status", 32'(status_tx), 32'hA0);
      if (i == 9) check_val("ovf_status", 32'(status_tx), 32'hB0);
    end
    pop_n(8);
    check_val("wrap_last_dout", 32'(fifo_dout_tx), 32'hB08);
    do_flush();

    // Pop while empty, then push+pop on an empty queue
    rd_en_tx = 1'b1;
    step("empty_pop");
    rd_en_tx = 1'b0;
    check_val("empty_pop_valid", 32'(fifo_dout_valid_tx), 32'd0);
    check_val("empty_pop_status", 32'(status_tx), 32'h48);
    write_enable_tx = 1'b1;
    reg_transmit_tx = 12'h123;
    rd_en_tx        = 1'b1;
    step("push_pop_empty");
    write_enable_tx = 1'b0;
    rd_en_tx        = 1'b0;
    check_val("pe_count", 32'(fifo_count_tx), 32'd1);
    check_val("pe_unf",   32'(status_tx[3]), 32'd1);
    pop_n(1);
    check_val("pe_dout", 32'(fifo_dout_tx), 32'h123);
    do_flush();

    // Full queue: simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push_word(12'hC00 + 12'(i), 1);
    write_enable_tx = 1'b1;
    reg_transmit_tx = 12'h7FF;
    rd_en_tx        = 1'b1;
    step("full_push_pop");
    write_enable_tx = 1'b0;
    rd_en_tx        = 1'b0;
    check_val("fpp_dout",  32'(fifo_dout_tx), 32'hC00);
    check_val("fpp_count", 32'(fifo_count_tx), 32'd8);
    check_val("fpp_ovf",   32'(status_tx[4]), 32'd0);
    pop_n(8);
    check_val("fpp_last", 32'(fifo_dout_tx), 32'h7FF);

    // Flush together with a push while 5 words are queued
    for (int i = 0; i < 5; i++) push_word(12'hD00 + 12'(i), 1);
    flush_tx        = 1'b1;
    write_enable_tx = 1'b1;
    reg_transmit_tx = 12'hDDD;
    step("flush_push");
    flush_tx        = 1'b0;
    write_enable_tx = 1'b0;
    check_val("fl_count",  32'(fifo_count_tx), 32'd0);
    check_val("fl_status", 32'(status_tx), 32'h40);
    pop_n(1);
    check_val("fl_unf_status", 32'(status_tx), 32'h48);

    // Asynchronous reset in the middle of a pop pulse
    push_word(12'hE01, 1);
    push_word(12'hE02, 1);
    rd_en_tx = 1'b1;
    step("pre_reset_pop");
    check_val("prerst_valid", 32'(fifo_dout_valid_tx), 32'd1);
    #2;
    PRESETn_tx = 1'b0;
    #1;
    model_reset();
    check_val("rst_dout",   32'(fifo_dout_tx), 32'h0);
    check_val("rst_valid",  32'(fifo_dout_valid_tx), 32'd0);
    check_val("rst_status", 32'(status_tx), 32'h40);
    compare_all("async_reset");
    rd_en_tx = 1'b0;
    #2;
    PRESETn_tx = 1'b1;
    step("post_reset");

    // Randomized phase
    for (int c = 0; c < 600; c++) begin
      write_enable_tx = ($urandom_range(0, 99) < 50);
      reg_transmit_tx = DW'($urandom);
      rd_en_tx        = ($urandom_range(0, 99) < 40);
      flush_tx        = ($urandom_range(0, 99) < 3);
      step("rand");
    end
    write_enable_tx = 1'b0;
    rd_en_tx        = 1'b0;
    flush_tx        = 1'b0;
    step("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
